ray_column_flattener: RTL and testbench



---
 rtl/ray_column_flattener.sv | 191 +++++++++++++++++++
 tb/tb_ray_column_flattener.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ray_column_flattener.sv
// Expands DDA column results into RGB565 frame-buffer writes (ceiling, wall, floor rows).
// Optional SIDE_SHADE_EN adds col_side_in and halves each wall colour channel for y-side hits.
module ray_column_flattener #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int PIXEL_WIDTH   = 16,
    parameter logic [PIXEL_WIDTH-1:0] CEILING_COLOR = 16'h2104,
    parameter logic [PIXEL_WIDTH-1:0] FLOOR_COLOR   = 16'h52AA
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   col_valid_in,
    output logic                   col_ready_out,
    input  logic [8:0]             col_x_in,
    input  logic [7:0]             col_height_in,
    input  logic [PIXEL_WIDTH-1:0] col_color_in,
    input  logic                   col_last_in,
`ifdef SIDE_SHADE_EN
    input  logic                   col_side_in,
`endif
    input  logic [1:0]             fb_switch_status_in,
    output logic [15:0]            ray_address_out,
    output logic [PIXEL_WIDTH-1:0] ray_pixel_out,
    output logic                   ray_valid_out,
    output logic                   ray_last_pixel_out,
    output logic                   busy_out
);

    localparam logic [7:0]  HEIGHT    = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  LAST_ROW  = 8'(SCREEN_HEIGHT - 1);
    localparam logic [15:0] ROW_STEP  = 16'(SCREEN_WIDTH);
    localparam logic [8:0]  X_LIMIT   = 9'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        WAIT_ACK,
        WAIT_SWAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]             y;
    logic [15:0]            addr;
    logic [7:0]             draw_start;
    logic [7:0]             draw_end;
    logic [PIXEL_WIDTH-1:0] wall_color;
    logic                   last_latched;
    logic                   offscreen;

    logic                   accept;
    logic [7:0]             h_clamp;
    logic [7:0]             in_start;
    logic [7:0]             in_end;
    logic [PIXEL_WIDTH-1:0] in_color;
    logic                   in_offscreen;

    logic [7:0]             row;
    logic [7:0]             row_start;
    logic [7:0]             row_end;
    logic [PIXEL_WIDTH-1:0] row_color;
    logic [PIXEL_WIDTH-1:0] row_pixel;
    logic [7:0]             y_next;
    logic [15:0]            addr_next;

    assign col_ready_out = (state == IDLE) && !rst_in;
    assign busy_out      = (state != IDLE);
    assign accept        = col_valid_in && col_ready_out;

    assign h_clamp      = (col_height_in > HEIGHT) ? HEIGHT : col_height_in;
    assign in_start     = (HEIGHT - h_clamp) >> 1;
    assign in_end       = in_start + h_clamp;
    assign in_offscreen = (col_x_in >= X_LIMIT);
    assign y_next       = y + 8'd1;
    assign addr_next    = addr + ROW_STEP;

`ifdef SIDE_SHADE_EN
    assign in_color = col_side_in
                    ? {1'b0, col_color_in[15:12], 1'b0, col_color_in[10:6], 1'b0, col_color_in[4:1]}
                    : col_color_in;
`else
    assign in_color = col_color_in;
`endif

    // The accept edge already registers row 0, so IDLE classifies it from the live inputs
    always_comb begin
        row       = 8'd0;
        row_start = in_start;
        row_end   = in_end;
        row_color = in_color;
        row_pixel = FLOOR_COLOR;
        if (state == DRAW) begin
            row       = y_next;
            row_start = draw_start;
            row_end   = draw_end;
            row_color = wall_color;
        end
        if (row < row_start) begin
            row_pixel = CEILING_COLOR;
        end else if (row < row_end) begin
            row_pixel = row_color;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = DRAW;
                end
            end
            DRAW: begin
                if (y == LAST_ROW) begin
                    next_state = last_latched ? WAIT_ACK : IDLE;
                end
            end
            WAIT_ACK: begin
                if (fb_switch_status_in[0]) begin
                    next_state = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (fb_switch_status_in == 2'b00) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Off-screen columns still walk every row so the last-pixel flag lands on the usual cycle
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            y                  <= 8'd0;
            addr               <= 16'd0;
            draw_start         <= 8'd0;
            draw_end           <= 8'd0;
            wall_color         <= '0;
            last_latched       <= 1'b0;
            offscreen          <= 1'b0;
            ray_address_out    <= 16'd0;
            ray_pixel_out      <= '0;
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
        end else begin
            ray_address_out    <= 16'd0;
            ray_pixel_out      <= '0;
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        y               <= 8'd0;
                        addr            <= {7'd0, col_x_in};
                        draw_start      <= in_start;
                        draw_end        <= in_end;
                        wall_color      <= in_color;
                        last_latched    <= col_last_in;
                        offscreen       <= in_offscreen;
                        ray_valid_out   <= !in_offscreen;
                        ray_address_out <= in_offscreen ? 16'd0 : {7'd0, col_x_in};
                        ray_pixel_out   <= in_offscreen ? '0 : row_pixel;
                    end
                end
                DRAW: begin
                    if (y != LAST_ROW) begin
                        y                  <= y_next;
                        addr               <= addr_next;
                        ray_valid_out      <= !offscreen;
                        ray_address_out    <= offscreen ? 16'd0 : addr_next;
                        ray_pixel_out      <= offscreen ? '0 : row_pixel;
                        ray_last_pixel_out <= last_latched && (y_next == LAST_ROW);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_column_flattener.sv
// Directed self-checking bench for ray_column_flattener; define SIDE_SHADE_EN to cover side shading.
module tb_ray_column_flattener;

    localparam int W = 320;
    localparam int H = 180;
    localparam logic [15:0] CEIL  = 16'h2104;
    localparam logic [15:0] FLOOR = 16'h52AA;

    logic        clk = 1'b0;
    logic        rst;
    logic        colValid;
    logic        colReady;
    logic [8:0]  colX;
    logic [7:0]  colHeight;
    logic [15:0] colColor;
    logic        colLast;
    logic        colSide;
    logic [1:0]  fbStatus;
    logic [15:0] rayAddress;
    logic [15:0] rayPixel;
    logic        rayValid;
    logic        rayLast;
    logic        busy;

    int assertions = 0;
    int failures   = 0;

    ray_column_flattener dut (
        .pixel_clk_in        (clk),
        .rst_in              (rst),
        .col_valid_in        (colValid),
        .col_ready_out       (colReady),
        .col_x_in            (colX),
        .col_height_in       (colHeight),
        .col_color_in        (colColor),
        .col_last_in         (colLast),
`ifdef SIDE_SHADE_EN
        .col_side_in         (colSide),
`endif
        .fb_switch_status_in (fbStatus),
        .ray_address_out     (rayAddress),
        .ray_pixel_out       (rayPixel),
        .ray_valid_out       (rayValid),
        .ray_last_pixel_out  (rayLast),
        .busy_out            (busy)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here so the counters stay honest
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one column and returns at the falling edge where its first pixel is visible
    task automatic applyStimulus(input logic [8:0] x, input logic [7:0] h, input logic [15:0] color,
                                 input logic last, input logic side);
        int waited;
        colX      = x;
        colHeight = h;
        colColor  = color;
        colLast   = last;
        colSide   = side;
        colValid  = 1'b1;
        waited    = 0;
        while (!colReady && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept ready", {31'd0, colReady}, 32'd1);
        @(negedge clk);
        colValid = 1'b0;
    endtask

    // Walks all rows of the column currently on the outputs against an independent model
    task automatic checkColumn(input int x, input int h, input logic [15:0] wallColor, input logic last);
        int hc;
        int ds;
        int de;
        logic [15:0] expPix;
        logic off;
        hc  = (h > H) ? H : h;
        ds  = (H - hc) / 2;
        de  = ds + hc;
        off = (x >= W);
        for (int y = 0; y < H; y++) begin
            if (y < ds)      expPix = CEIL;
            else if (y < de) expPix = wallColor;
            else             expPix = FLOOR;
            checkOutput($sformatf("valid x=%0d y=%0d", x, y), {31'd0, rayValid}, off ? 32'd0 : 32'd1);
            checkOutput($sformatf("addr x=%0d y=%0d", x, y), {16'd0, rayAddress}, off ? 32'd0 : 32'(x + W * y));
            if (!off) begin
                checkOutput($sformatf("pixel x=%0d y=%0d", x, y), {16'd0, rayPixel}, {16'd0, expPix});
            end
            checkOutput($sformatf("last x=%0d y=%0d", x, y), {31'd0, rayLast}, (last && y == H - 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("ready x=%0d y=%0d", x, y), {31'd0, colReady}, 32'd0);
            @(negedge clk);
        end
        checkOutput("post valid", {31'd0, rayValid}, 32'd0);
        checkOutput("post last", {31'd0, rayLast}, 32'd0);
        checkOutput("post ready", {31'd0, colReady}, last ? 32'd0 : 32'd1);
        checkOutput("post busy", {31'd0, busy}, last ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        colValid  = 1'b0;
        colX      = 9'd0;
        colHeight = 8'd0;
        colColor  = 16'd0;
        colLast   = 1'b0;
        colSide   = 1'b0;
        fbStatus  = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("reset ready", {31'd0, colReady}, 32'd0);
        checkOutput("reset valid", {31'd0, rayValid}, 32'd0);
        checkOutput("reset addr", {16'd0, rayAddress}, 32'd0);
        checkOutput("reset pixel", {16'd0, rayPixel}, 32'd0);
        checkOutput("reset last", {31'd0, rayLast}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready after reset", {31'd0, colReady}, 32'd1);

        $display("[TB] basic column and height boundaries");
        applyStimulus(9'd0, 8'd60, 16'hF800, 1'b0, 1'b0);
        checkColumn(0, 60, 16'hF800, 1'b0);
        fbStatus = 2'b11;
        applyStimulus(9'd5, 8'd61, 16'h07E0, 1'b0, 1'b0);
        checkColumn(5, 61, 16'h07E0, 1'b0);
        fbStatus = 2'b00;
        applyStimulus(9'd5, 8'd255, 16'h001F, 1'b0, 1'b0);
        checkColumn(5, 255, 16'h001F, 1'b0);
        applyStimulus(9'd100, 8'd0, 16'h1234, 1'b0, 1'b0);
        checkColumn(100, 0, 16'h1234, 1'b0);

        $display("[TB] last column and buffer swap handshake");
        applyStimulus(9'd319, 8'd20, 16'hABCD, 1'b1, 1'b0);
        checkColumn(319, 20, 16'hABCD, 1'b1);
        colX      = 9'd7;
        colHeight = 8'd100;
        colColor  = 16'h5A5A;
        colLast   = 1'b0;
        colValid  = 1'b1;
        fbStatus  = 2'b00;
        @(negedge clk);
        checkOutput("wait ack status00", {31'd0, colReady}, 32'd0);
        fbStatus = 2'b01;
        @(negedge clk);
        checkOutput("wait swap status01", {31'd0, colReady}, 32'd0);
        checkOutput("wait swap busy", {31'd0, busy}, 32'd1);
        fbStatus = 2'b11;
        @(negedge clk);
        checkOutput("wait swap status11", {31'd0, colReady}, 32'd0);
        fbStatus = 2'b00;
        @(negedge clk);
        checkOutput("swap done ready", {31'd0, colReady}, 32'd1);
        checkOutput("swap done valid", {31'd0, rayValid}, 32'd0);
        @(negedge clk);
        colValid = 1'b0;
        checkColumn(7, 100, 16'h5A5A, 1'b0);

        $display("[TB] reset in the middle of a column");
        applyStimulus(9'd9, 8'd90, 16'h0F0F, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("mid addr y50", {16'd0, rayAddress}, 32'(9 + W * 50));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset valid", {31'd0, rayValid}, 32'd0);
        checkOutput("mid reset addr", {16'd0, rayAddress}, 32'd0);
        checkOutput("mid reset pixel", {16'd0, rayPixel}, 32'd0);
        checkOutput("mid reset last", {31'd0, rayLast}, 32'd0);
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid reset ready", {31'd0, colReady}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid release ready", {31'd0, colReady}, 32'd1);
        applyStimulus(9'd11, 8'd40, 16'hC3C3, 1'b0, 1'b0);
        checkColumn(11, 40, 16'hC3C3, 1'b0);

        $display("[TB] off-screen last column");
        applyStimulus(9'd320, 8'd50, 16'hFFFF, 1'b1, 1'b0);
        checkColumn(320, 50, 16'hFFFF, 1'b1);
        fbStatus = 2'b01;
        @(negedge clk);
        fbStatus = 2'b00;
        @(negedge clk);
        checkOutput("offscreen swap ready", {31'd0, colReady}, 32'd1);

`ifdef SIDE_SHADE_EN
        $display("[TB] side shading");
        applyStimulus(9'd3, 8'd180, 16'hFFFF, 1'b0, 1'b1);
        checkColumn(3, 180, 16'h7BEF, 1'b0);
        applyStimulus(9'd3, 8'd180, 16'hFFFF, 1'b0, 1'b0);
        checkColumn(3, 180, 16'hFFFF, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
